// File: rtl/municao_jogador_if.sv
// Signal bundle between the player ammunition block and the rest of the game:
// fire button, ship/enemy positions and VGA counters in; bullet state and pixel colour out.
interface municao_jogador_if;
   logic        btn_fire;
   logic [10:0] posX_player;
   logic [10:0] posY_player;
   logic [10:0] posX_enemy;
   logic [10:0] posY_enemy;
   logic [9:0]  h_counter;
   logic [9:0]  v_counter;
   logic [10:0] posX_shot;
   logic [10:0] posY_shot;
   logic        shot_active;
   logic        hit_pulse;
   logic [7:0]  hit_count;
   logic [7:0]  R;
   logic [7:0]  G;
   logic [7:0]  B;

   // Game side: drives the button, positions and scan counters.
   modport master (
      output btn_fire, posX_player, posY_player, posX_enemy, posY_enemy, h_counter, v_counter,
      input  posX_shot, posY_shot, shot_active, hit_pulse, hit_count, R, G, B
   );

   // Ammunition block side.
   modport slave (
      input  btn_fire, posX_player, posY_player, posX_enemy, posY_enemy, h_counter, v_counter,
      output posX_shot, posY_shot, shot_active, hit_pulse, hit_count, R, G, B
   );
endinterface

// File: rtl/municao_jogador.sv
// Player bullet: one launch per fire press, climbs one pixel per move tick,
// detects overlap with the enemy box, counts hits and paints the bullet pixels.
module municao_jogador #(
   parameter int MOVE_DELAY   = 500000,
   parameter int COOLDOWN     = 10000000,
   parameter int FLASH_CYCLES = 5000000,
   parameter int TOP_LIMIT    = 2,
   parameter int BULLET_W     = 2,
   parameter int BULLET_H     = 20,
   parameter int ENEMY_W      = 40,
   parameter int ENEMY_H      = 30
) (
   input logic              clk,
   input logic              reset,
   municao_jogador_if.slave bus
);
   localparam int MOVE_W  = $clog2(MOVE_DELAY + 1);
   localparam int COOL_W  = $clog2(COOLDOWN + 1);
   localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_FLYING, S_FLASH} state_t;

   state_t             r_state, w_state_next;
   logic               r_sync1, r_sync2, r_btn_prev;
   logic [MOVE_W-1:0]  r_move_cnt;
   logic [COOL_W-1:0]  r_cool_cnt;
   logic [FLASH_W-1:0] r_flash_cnt, w_flash_next;
   logic [10:0]        r_pos_x, r_pos_y, w_pos_x_next, w_pos_y_next;
   logic               r_hit_pulse, w_hit_pulse_next;
   logic [7:0]         r_hit_count, w_hit_count_next;
   logic [7:0]         r_red, r_green, r_blue;
   logic               w_fire_req, w_tick, w_launch, w_hit, w_at_top;
   logic               w_blank, w_in_bullet;
   logic [10:0]        w_h, w_v;

   // Bring the raw button into the clock domain and keep one flop of history for edge detection.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_btn_prev <= 1'b0;
      end else begin
         r_sync1    <= bus.btn_fire;
         r_sync2    <= r_sync1;
         r_btn_prev <= r_sync2;
      end
   end

   // A held button yields a single request on its rising edge.
   assign w_fire_req = r_sync2 & ~r_btn_prev;
   assign w_tick     = (r_move_cnt == MOVE_W'(MOVE_DELAY));
   assign w_launch   = (r_state == S_IDLE) && w_fire_req && (r_cool_cnt == '0);

   // Free-running move timer, 0..MOVE_DELAY inclusive.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_move_cnt <= '0;
      else if (w_tick) r_move_cnt <= '0;
      else             r_move_cnt <= r_move_cnt + MOVE_W'(1);
   end

   // Shot cooldown: reloaded on launch, counts down to zero and rests there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  r_cool_cnt <= '0;
      else if (w_launch)          r_cool_cnt <= COOL_W'(COOLDOWN);
      else if (r_cool_cnt != '0)  r_cool_cnt <= r_cool_cnt - COOL_W'(1);
   end

   // Rectangle overlap with additions only, so nothing depends on subtraction wrap-around.
   assign w_hit = (r_pos_x < bus.posX_enemy + 11'(ENEMY_W)) &&
                  (r_pos_x + 11'(BULLET_W) > bus.posX_enemy) &&
                  (r_pos_y < bus.posY_enemy + 11'(ENEMY_H)) &&
                  (r_pos_y + 11'(BULLET_H) > bus.posY_enemy);
   // Checked before the decrement, so posY_shot can never underflow.
   assign w_at_top = (r_pos_y <= 11'(TOP_LIMIT));

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next state: a hit outranks the top-of-screen miss.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_launch) w_state_next = S_FLYING;
         S_FLYING: begin
            if (w_hit)                  w_state_next = S_FLASH;
            else if (w_tick && w_at_top) w_state_next = S_IDLE;
         end
         S_FLASH:  if (r_flash_cnt <= FLASH_W'(1)) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs: next values of position, hit bookkeeping and flash timer.
   always_comb begin
      w_pos_x_next     = r_pos_x;
      w_pos_y_next     = r_pos_y;
      w_hit_pulse_next = 1'b0;
      w_hit_count_next = r_hit_count;
      w_flash_next     = r_flash_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_launch) begin
               w_pos_x_next = bus.posX_player;
               w_pos_y_next = bus.posY_player;
            end
         end
         S_FLYING: begin
            if (w_hit) begin
               w_hit_pulse_next = 1'b1;
               w_flash_next     = FLASH_W'(FLASH_CYCLES);
               if (r_hit_count != 8'hFF) w_hit_count_next = r_hit_count + 8'd1;
            end else if (w_tick && !w_at_top) begin
               w_pos_y_next = r_pos_y - 11'd1;
            end
         end
         S_FLASH: begin
            if (r_flash_cnt != '0) w_flash_next = r_flash_cnt - FLASH_W'(1);
         end
         default: ;
      endcase
   end

   // Datapath registers fed by the FSM output logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pos_x     <= '0;
         r_pos_y     <= '0;
         r_hit_pulse <= 1'b0;
         r_hit_count <= '0;
         r_flash_cnt <= '0;
      end else begin
         r_pos_x     <= w_pos_x_next;
         r_pos_y     <= w_pos_y_next;
         r_hit_pulse <= w_hit_pulse_next;
         r_hit_count <= w_hit_count_next;
         r_flash_cnt <= w_flash_next;
      end
   end

   assign w_h         = {1'b0, bus.h_counter};
   assign w_v         = {1'b0, bus.v_counter};
   assign w_blank     = (w_v <= 11'd2) || (w_h <= 11'd96);
   assign w_in_bullet = (w_h >= r_pos_x) && (w_h < r_pos_x + 11'(BULLET_W)) &&
                        (w_v >= r_pos_y) && (w_v < r_pos_y + 11'(BULLET_H));

   // Pixel colour, one cycle behind the scan counters: yellow in flight, white while flashing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else if (w_blank) begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else if (r_state == S_FLYING && w_in_bullet) begin
         r_red   <= 8'hFF;
         r_green <= 8'hFF;
         r_blue  <= 8'h00;
      end else if (r_state == S_FLASH && w_in_bullet) begin
         r_red   <= 8'hFF;
         r_green <= 8'hFF;
         r_blue  <= 8'hFF;
      end else begin
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end
   end

   assign bus.posX_shot   = r_pos_x;
   assign bus.posY_shot   = r_pos_y;
   assign bus.shot_active = (r_state == S_FLYING);
   assign bus.hit_pulse   = r_hit_pulse;
   assign bus.hit_count   = r_hit_count;
   assign bus.R           = r_red;
   assign bus.G           = r_green;
   assign bus.B           = r_blue;
endmodule

// File: tb/tb_municao_jogador.sv
// Bench for municao_jogador: a timestamp-based reference model runs alongside the DUT and is
// compared every cycle, with directed sequences, a pixel vector table and a random phase.
module tb_municao_jogador;
   localparam int MD = 3, CD = 40, FC = 4, TOP = 2;
   localparam int BW = 2, BH = 20, EW = 40, EH = 30;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   municao_jogador_if bus();

   municao_jogador #(.MOVE_DELAY(MD), .COOLDOWN(CD), .FLASH_CYCLES(FC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_total++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Reference model, expressed in edge timestamps since reset release.
   typedef enum {M_IDLE, M_FLY, M_FLASH} mphase_t;
   mphase_t m_phase;
   int m_x, m_y, m_count, m_n, m_last_launch, m_flash_end;
   int m_r, m_g, m_b;
   bit m_pulse;
   int m_btn_q[$];

   task automatic model_clear();
      m_phase = M_IDLE;
      m_x = 0; m_y = 0; m_count = 0; m_n = 0;
      m_last_launch = -100000; m_flash_end = 0;
      m_r = 0; m_g = 0; m_b = 0; m_pulse = 0;
      m_btn_q.delete();
   endtask

   task automatic model_step();
      int sz, h, v;
      bit fire, tick, in_rect, hit;
      m_n++;
      m_btn_q.push_back(int'(bus.btn_fire));
      if (m_btn_q.size() > 4) void'(m_btn_q.pop_front());
      sz   = m_btn_q.size();
      // Launch happens two edges after the edge that first sees the button high.
      fire = (sz >= 3 && m_btn_q[sz-3] == 1) && !(sz >= 4 && m_btn_q[sz-4] == 1);
      tick = (m_n % (MD + 1)) == 0;

      h = int'(bus.h_counter);
      v = int'(bus.v_counter);
      in_rect = (h >= m_x) && (h < m_x + BW) && (v >= m_y) && (v < m_y + BH);
      if (v <= 2 || h <= 96)               begin m_r = 0;   m_g = 0;   m_b = 0;   end
      else if (m_phase == M_FLY && in_rect)   begin m_r = 255; m_g = 255; m_b = 0;   end
      else if (m_phase == M_FLASH && in_rect) begin m_r = 255; m_g = 255; m_b = 255; end
      else                                 begin m_r = 0;   m_g = 0;   m_b = 0;   end

      m_pulse = 0;
      case (m_phase)
         M_IDLE: if (fire && (m_n - 1 - m_last_launch >= CD)) begin
            m_phase = M_FLY;
            m_x = int'(bus.posX_player);
            m_y = int'(bus.posY_player);
            m_last_launch = m_n;
         end
         M_FLY: begin
            hit = (m_x < int'(bus.posX_enemy) + EW) && (m_x + BW > int'(bus.posX_enemy)) &&
                  (m_y < int'(bus.posY_enemy) + EH) && (m_y + BH > int'(bus.posY_enemy));
            if (hit) begin
               m_phase = M_FLASH;
               m_pulse = 1;
               m_flash_end = m_n + FC;
               if (m_count < 255) m_count++;
            end else if (tick) begin
               if (m_y <= TOP) m_phase = M_IDLE;
               else m_y--;
            end
         end
         M_FLASH: if (m_n == m_flash_end) m_phase = M_IDLE;
         default: ;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (reset) model_clear();
         else model_step();
      end
   end

   bit chk_en = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && !reset) begin
            check("posX_shot",   int'(bus.posX_shot),   m_x);
            check("posY_shot",   int'(bus.posY_shot),   m_y);
            check("shot_active", int'(bus.shot_active), (m_phase == M_FLY) ? 1 : 0);
            check("hit_pulse",   int'(bus.hit_pulse),   int'(m_pulse));
            check("hit_count",   int'(bus.hit_count),   m_count);
            check("R", int'(bus.R), m_r);
            check("G", int'(bus.G), m_g);
            check("B", int'(bus.B), m_b);
         end
      end
   end

   // Launches observed on the DUT, counted on shot_active rising edges.
   int launches_seen = 0;
   bit prev_active = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (bus.shot_active && !prev_active) launches_seen++;
         prev_active = bus.shot_active;
      end
   end

   task automatic do_reset(input int cycles);
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      check("rst_shot_active", int'(bus.shot_active), 0);
      check("rst_hit_count",   int'(bus.hit_count),   0);
      check("rst_hit_pulse",   int'(bus.hit_pulse),   0);
      check("rst_posY_shot",   int'(bus.posY_shot),   0);
      check("rst_R",           int'(bus.R),           0);
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic press(input int cycles);
      bus.btn_fire = 1'b1;
      repeat (cycles) @(negedge clk);
      bus.btn_fire = 1'b0;
   endtask

   // which: 0 = shot_active, 1 = hit_pulse; waits at most 'limit' cycles for 'level'.
   task automatic wait_for(input string name, input int which, input bit level, input int limit);
      bit found = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (((which == 0) ? bus.shot_active : bus.hit_pulse) == level) begin
            found = 1;
            break;
         end
      end
      check(name, int'(found), 1);
   endtask

   typedef struct { int h; int v; int r; int g; int b; } pix_vec_t;
   pix_vec_t pix_tab[9];

   initial begin
      int lat, base;

      // Bullet spawned at (100,150), at most three ticks old: rows span [147..150, +20).
      pix_tab[0] = '{101, 160, 255, 255, 0};
      pix_tab[1] = '{102, 160, 0, 0, 0};
      pix_tab[2] = '{90,  160, 0, 0, 0};
      pix_tab[3] = '{100, 155, 255, 255, 0};
      pix_tab[4] = '{99,  160, 0, 0, 0};
      pix_tab[5] = '{101, 146, 0, 0, 0};
      pix_tab[6] = '{100, 170, 0, 0, 0};
      pix_tab[7] = '{100, 165, 255, 255, 0};
      pix_tab[8] = '{101, 2,   0, 0, 0};

      bus.btn_fire    = 1'b1;
      bus.posX_player = 11'd0;
      bus.posY_player = 11'd0;
      bus.posX_enemy  = 11'd300;
      bus.posY_enemy  = 11'd100;
      bus.h_counter   = 10'd0;
      bus.v_counter   = 10'd0;
      model_clear();

      // Reset with the button held, release the button, then leave reset.
      repeat (3) @(negedge clk);
      check("reset_shot_active", int'(bus.shot_active), 0);
      check("reset_hit_count",   int'(bus.hit_count),   0);
      check("reset_posX_shot",   int'(bus.posX_shot),   0);
      check("reset_G",           int'(bus.G),           0);
      bus.btn_fire = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      chk_en = 1;
      repeat (10) @(negedge clk);
      check("no_launch_after_reset", launches_seen, 0);

      // First launch: latency, spawn point, climb rate, then abort by reset mid-flight.
      bus.posX_player = 11'd100;
      bus.posY_player = 11'd200;
      bus.btn_fire    = 1'b1;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus.shot_active) begin
            lat = i;
            break;
         end
      end
      check("launch_latency", lat, 3);
      bus.btn_fire = 1'b0;
      check("spawn_x", int'(bus.posX_shot), 100);
      check("spawn_y", int'(bus.posY_shot), 200);
      repeat (8) @(negedge clk);
      check("y_after_8_cycles", int'(bus.posY_shot), 198);
      do_reset(2);

      // Held button: one launch, bullet discarded at the top, no hit counted.
      bus.posX_player = 11'd100;
      bus.posY_player = 11'd10;
      base = launches_seen;
      bus.btn_fire = 1'b1;
      repeat (100) @(negedge clk);
      check("held_button_launches", launches_seen - base, 1);
      check("top_miss_inactive", int'(bus.shot_active), 0);
      check("top_miss_final_y",  int'(bus.posY_shot),   2);
      check("top_miss_hits",     int'(bus.hit_count),   0);
      bus.btn_fire = 1'b0;

      // Press shortly after a quick miss is dropped by cooldown; a later press is accepted.
      repeat (50) @(negedge clk);
      bus.posY_player = 11'd5;
      base = launches_seen;
      press(2);
      wait_for("short_flight_start", 0, 1'b1, 10);
      wait_for("short_flight_end",   0, 1'b0, 40);
      repeat (10) @(negedge clk);
      press(2);
      repeat (10) @(negedge clk);
      check("cooldown_drop_launches", launches_seen - base, 1);
      check("cooldown_drop_inactive", int'(bus.shot_active), 0);
      repeat (40) @(negedge clk);
      press(2);
      wait_for("post_cooldown_launch", 0, 1'b1, 10);
      @(negedge clk);
      check("post_cooldown_launches", launches_seen - base, 2);
      wait_for("post_cooldown_end", 0, 1'b0, 40);

      // Hit: one-cycle pulse, count of one, four cycles of white flash at the frozen spot.
      repeat (50) @(negedge clk);
      bus.posX_player = 11'd310;
      bus.posY_player = 11'd135;
      bus.h_counter   = 10'd311;
      bus.v_counter   = 10'd140;
      press(2);
      wait_for("hit_seen", 1, 1'b1, 100);
      check("hit_count_one",     int'(bus.hit_count),   1);
      check("hit_clears_active", int'(bus.shot_active), 0);
      check("hit_frozen_y",      int'(bus.posY_shot),   129);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) check("hit_pulse_width", int'(bus.hit_pulse), 0);
         check($sformatf("flash_white_%0d", i), int'(bus.B), 255);
      end
      @(negedge clk);
      check("flash_over_black", int'(bus.R), 0);

      // Pixel table while flying from (100,150).
      repeat (50) @(negedge clk);
      bus.posX_player = 11'd100;
      bus.posY_player = 11'd150;
      press(2);
      wait_for("table_launch", 0, 1'b1, 10);
      for (int k = 0; k < 9; k++) begin
         bus.h_counter = 10'(pix_tab[k].h);
         bus.v_counter = 10'(pix_tab[k].v);
         @(negedge clk);
         check($sformatf("pix%0d_R", k), int'(bus.R), pix_tab[k].r);
         check($sformatf("pix%0d_G", k), int'(bus.G), pix_tab[k].g);
         check($sformatf("pix%0d_B", k), int'(bus.B), pix_tab[k].b);
      end
      wait_for("table_flight_end", 0, 1'b0, 1000);

      // Point-blank shots until the hit counter saturates.
      bus.posX_player = 11'd310;
      bus.posY_player = 11'd110;
      for (int k = 0; k < 260; k++) begin
         press(1);
         repeat (49) @(negedge clk);
      end
      check("hit_count_saturated", int'(bus.hit_count), 255);

      // Random phase; the reset here also shows the counter clearing from 255.
      do_reset(2);
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(7) == 0) bus.btn_fire = ~bus.btn_fire;
         if ($urandom_range(49) == 0) begin
            bus.posX_player = 11'($urandom_range(400, 200));
            bus.posY_player = 11'($urandom_range(250, 20));
         end
         if ($urandom_range(199) == 0) begin
            bus.posX_enemy = 11'($urandom_range(350, 250));
            bus.posY_enemy = 11'($urandom_range(200, 50));
         end
         if ($urandom_range(1) == 0) begin
            bus.h_counter = 10'(m_x + int'($urandom_range(3)) - 1);
            bus.v_counter = 10'(m_y + int'($urandom_range(22)) - 1);
         end else begin
            bus.h_counter = 10'($urandom_range(1023));
            bus.v_counter = 10'($urandom_range(1023));
         end
         if (k == 2500) do_reset(1);
         @(negedge clk);
      end

      chk_en = 0;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
